dbus_mem_responder: RTL and testbench



---
 rtl/dbus_mem_responder.sv | 139 +++++++++++++
 tb/tb_dbus_mem_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dbus_mem_responder.sv
// rtl/dbus_mem_responder.sv - data-bus load/store responder with a 64-bit word store
//
// Serves one request at a time over a valid / addr_ok / data_ok handshake.
// A request is accepted in IDLE, waits LATENCY cycles, then answers in RESP.
// In RESP the response returns the word as it was before any write. Byte-strobe
// stores are applied on the edge that leaves RESP.
//
// Optional feature macro: DBUS_MISALIGN_CHECK_EN
//   When it is defined, a naturally misaligned access (or req_size > 3) still
//   gets a response, but with resp_err=1 and resp_data=0, and its store is
//   suppressed. When it is undefined, resp_err stays 0 and the low address
//   bits are ignored.
//
// Ports:
//   clk           clock, all state on rising edge
//   resetn        asynchronous active-low reset
//   req_valid     request present, held until the data_ok cycle
//   req_addr      byte address; word index = req_addr[3 +: log2(DEPTH)]
//   req_size      log2 of access bytes
//   req_strobe    byte-lane write enables, 0 = load
//   req_data      lane-aligned store data
//   resp_addr_ok  request accepted this cycle (combinational in IDLE)
//   resp_data_ok  response valid this cycle
//   resp_data     pre-write word of the addressed location
//   resp_err      misaligned-access error
module dbus_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        resp_err
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] LAT    = 4'(LATENCY);

  logic [1:0]    state;
  logic [3:0]    count;
  logic [AW-1:0] idx_q;
  logic [7:0]    strobe_q;
  logic [63:0]   data_q;
  logic          mis_q;

  logic [63:0]   mem [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic [AW-1:0] req_idx;
  logic          req_mis;
  logic [AW-1:0] rd_idx;
  logic          rd_mis;
  logic          unused_ok;

  // addr_ok is gated by resetn so every output reads 0 while reset is held.
  assign accept       = resetn && (state == S_IDLE) && req_valid;
  assign resp_addr_ok = accept;
  assign resp_data_ok = (state == S_RESP);

  assign req_idx = req_addr[3 +: AW];

`ifdef DBUS_MISALIGN_CHECK_EN
  // Natural alignment: the low address bits below the access size must be 0.
  // For size 3 the 3-bit mask (1<<3)-1 wraps to 3'b111, which is the right mask.
  assign req_mis = (req_size > 3'd3) ||
                   ((req_addr[2:0] & ((3'd1 << req_size) - 3'd1)) != 3'd0);
`else
  assign req_mis = 1'b0;
`endif

  // The word is read on the edge that enters RESP. With LATENCY=0 that edge is
  // also the acceptance edge, so the read uses the live request instead of the
  // latched copy.
  assign enter_resp = (accept && (LAT == 4'd0)) ||
                      ((state == S_WAIT) && (count == 4'd1));
  assign rd_idx     = (state == S_IDLE) ? req_idx : idx_q;
  assign rd_mis     = (state == S_IDLE) ? req_mis : mis_q;

  // Address bits outside the word index never select anything.
  assign unused_ok = ^{req_addr[63:3+AW], req_addr[2:0], req_size};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      count     <= 4'd0;
      idx_q     <= '0;
      strobe_q  <= 8'd0;
      data_q    <= 64'd0;
      mis_q     <= 1'b0;
      resp_data <= 64'd0;
      resp_err  <= 1'b0;
    end else begin
      if (enter_resp) begin
        resp_data <= rd_mis ? 64'd0 : mem[rd_idx];
        resp_err  <= rd_mis;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            idx_q    <= req_idx;
            strobe_q <= req_strobe;
            data_q   <= req_data;
            mis_q    <= req_mis;
            count    <= LAT;
            state    <= (LAT == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The store is applied when RESP is left. A reset during WAIT/RESP forces
  // the state to IDLE at once, so an aborted request never reaches this write.
  always_ff @(posedge clk) begin
    if ((state == S_RESP) && !mis_q) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_q[i]) mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb/tb_dbus_mem_responder.sv - randomized self-checking bench for dbus_mem_responder
module tb_dbus_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;
  logic        resp_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] got;

  dbus_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_strobe   (req_strobe),
    .req_data     (req_data),
    .resp_addr_ok (resp_addr_ok),
    .resp_data_ok (resp_data_ok),
    .resp_data    (resp_data),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_misaligned(input logic [63:0] a, input logic [2:0] sz);
`ifdef DBUS_MISALIGN_CHECK_EN
    if (sz > 3) return 1'b1;
    return (a % (64'd1 << sz)) != 64'd0;
`else
    return 1'b0;
`endif
  endfunction

  // One complete transaction, entered and left at 1 time unit after a rising edge.
  task automatic xfer(input logic [63:0] a, input logic [2:0] sz, input logic [7:0] st,
                      input logic [63:0] d, input bit chk, input bit scramble,
                      output logic [63:0] obs);
    int          idx;
    int          n;
    bit          exp_err;
    logic [63:0] exp_data;
    idx      = int'((a >> 3) % DEPTH);
    exp_err  = is_misaligned(a, sz);
    exp_data = exp_err ? 64'd0 : model[idx];
    req_valid = 1'b1; req_addr = a; req_size = sz; req_strobe = st; req_data = d;
    @(negedge clk);
    if (chk) begin
      check("addr_ok_accept", resp_addr_ok, 1);
      check("data_ok_at_accept", resp_data_ok, 0);
    end
    @(posedge clk); #1;
    if (scramble) begin
      req_addr = {$urandom, $urandom}; req_data = {$urandom, $urandom};
      req_strobe = 8'($urandom); req_size = 3'($urandom);
    end
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      if (resp_data_ok) break;
      if (chk) check("addr_ok_while_busy", resp_addr_ok, 0);
      n++;
    end
    obs = resp_data;
    if (chk) begin
      check("latency", 64'(n), 64'(LATENCY + 1));
      check("resp_data", resp_data, exp_data);
      check("resp_err", resp_err, 64'(exp_err));
    end
    if (!exp_err)
      for (int i = 0; i < 8; i++)
        if (st[i]) model[idx][8*i +: 8] = d[8*i +: 8];
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [63:0] a;
    logic [2:0]  sz;
    logic [7:0]  st;
    resetn = 1'b0; req_valid = 1'b1; req_addr = 64'd0; req_size = 3'd3;
    req_strobe = 8'd0; req_data = 64'd0;
    for (int i = 0; i < DEPTH; i++) model[i] = 64'd0;

    // Reset state, with req_valid high to show addr_ok held low during reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr_ok", resp_addr_ok, 0);
    check("rst_data_ok", resp_data_ok, 0);
    check("rst_data", resp_data, 0);
    check("rst_err", resp_err, 0);
    req_valid = 1'b0; resetn = 1'b1;
    @(posedge clk); #1;

    // Preload the whole store with zeros through the bus.
    for (int i = 0; i < DEPTH; i++) xfer(64'(i) * 8, 3'd3, 8'hFF, 64'd0, 1'b0, 1'b0, got);

    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("idle_no_data_ok", resp_data_ok, 0);
    end
    @(posedge clk); #1;

    xfer(64'h0, 3'd3, 8'h00, 64'd0, 1'b1, 1'b0, got);
    check("load0", got, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("no_stray_data_ok", resp_data_ok, 0);
    end
    @(posedge clk); #1;

    xfer(64'h40, 3'd3, 8'hFF, 64'h1122334455667788, 1'b1, 1'b0, got);
    xfer(64'h40, 3'd3, 8'h00, 64'd0, 1'b1, 1'b0, got);
    check("full_store_load", got, 64'h1122334455667788);

    xfer(64'h40, 3'd3, 8'hC0, 64'hAAAA_0000_0000_0000, 1'b1, 1'b0, got);
    check("pre_write_word", got, 64'h1122334455667788);
    xfer(64'h40, 3'd3, 8'h00, 64'd0, 1'b1, 1'b0, got);
    check("strobe_merge", got, 64'hAAAA334455667788);

    xfer(64'h2000, 3'd3, 8'h03, 64'hDEAD, 1'b1, 1'b0, got);
    xfer(64'h0, 3'd3, 8'h00, 64'd0, 1'b1, 1'b0, got);
    check("wrap_low16", 64'(got[15:0]), 64'hDEAD);

    // Reset while the store waits: outputs drop at once and the store is lost.
    xfer(64'h80, 3'd3, 8'hFF, 64'h0123456789ABCDEF, 1'b1, 1'b0, got);
    req_valid = 1'b1; req_addr = 64'h80; req_size = 3'd3;
    req_strobe = 8'hFF; req_data = 64'hBADBADBADBADBAD0;
    @(negedge clk); check("abort_accept", resp_addr_ok, 1);
    @(posedge clk); #2;
    resetn = 1'b0; #1;
    check("abort_addr_ok", resp_addr_ok, 0);
    check("abort_data_ok", resp_data_ok, 0);
    check("abort_data", resp_data, 0);
    check("abort_err", resp_err, 0);
    req_valid = 1'b0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    xfer(64'h80, 3'd3, 8'h00, 64'd0, 1'b1, 1'b0, got);
    check("abort_store_dropped", got, 64'h0123456789ABCDEF);

    // Misaligned doubleword store.
    xfer(64'h44, 3'd3, 8'hFF, 64'h5555666677778888, 1'b1, 1'b0, got);
    xfer(64'h40, 3'd3, 8'h00, 64'd0, 1'b1, 1'b0, got);
`ifdef DBUS_MISALIGN_CHECK_EN
    check("misalign_mem_kept", got, 64'hAAAA334455667788);
`else
    check("misalign_ignored", got, 64'h5555666677778888);
`endif

    // Random traffic on a small aliased window, with request changes after acceptance.
    for (int k = 0; k < 200; k++) begin
      a = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_E07F;
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      st = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom);
      xfer(a, sz, st, {$urandom, $urandom}, 1'b1, $urandom_range(0, 1) == 1, got);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
